asic_fetch_decode: RTL and testbench

//  - Instruction fetch/decode stage directly downstream of the instruction ROM (asic_rom).
//  - Drives the ROM read port (ena/addr) from an internal program counter.
//  - Captures each 16-bit word and splits it into opcode/reg/imm fields.
//  - Presents each decoded instruction to the execute stage over a valid/ready handshake;

---
 rtl/asic_isa_pkg.sv | 33 +++
 rtl/asic_fetch_decode_if.sv | 32 +++
 rtl/asic_ins_decode.sv | 17 +
 rtl/asic_fetch_decode.sv | 114 +++++++++++
 tb/tb_asic_fetch_decode.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/asic_isa_pkg.sv
// Shared ISA definitions for the fetch/decode stage: FSM state encoding,
// instruction field positions and opcode constants.
package asic_isa_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_ISSUE   = 3'd3;
  localparam logic [2:0] S_HALT    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = S_IDLE,
    ST_FETCH   = S_FETCH,
    ST_CAPTURE = S_CAPTURE,
    ST_ISSUE   = S_ISSUE,
    ST_HALT    = S_HALT
  } state_t;

  // Field layout of a 16-bit instruction word
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int REG_MSB = 11;
  localparam int REG_LSB = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_HALT = 4'hF;

  function automatic logic is_halt(input logic [3:0] op);
    return op == OP_HALT;
  endfunction

endpackage

// File: rtl/asic_fetch_decode_if.sv
// ROM read port, start control and decoded-instruction handshake of the fetch/decode stage.
// The master modport is the fetch/decode side; the slave modport is the ROM/execute environment.
interface asic_fetch_decode_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int D_WIDTH    = 16
);

  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic                  rom_ena;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [D_WIDTH-1:0]    rom_data;
  logic                  ins_valid;
  logic                  ins_ready;
  logic [3:0]            ins_op;
  logic [3:0]            ins_reg;
  logic [7:0]            ins_imm;
  logic [ADDR_WIDTH-1:0] ins_pc;
  logic                  busy;
  logic                  halted;

  modport master (
    input  start, start_addr, rom_data, ins_ready,
    output rom_ena, rom_addr, ins_valid, ins_op, ins_reg, ins_imm, ins_pc, busy, halted
  );

  modport slave (
    output start, start_addr, rom_data, ins_ready,
    input  rom_ena, rom_addr, ins_valid, ins_op, ins_reg, ins_imm, ins_pc, busy, halted
  );

endinterface

// File: rtl/asic_ins_decode.sv
// Combinational splitter of an instruction word into opcode, register and immediate fields.
module asic_ins_decode
  import asic_isa_pkg::*;
#(
  parameter int D_WIDTH = 16
) (
  input  logic [D_WIDTH-1:0] word,
  output logic [3:0]         op,
  output logic [3:0]         rfield,
  output logic [7:0]         imm
);

  assign op     = word[OP_MSB:OP_LSB];
  assign rfield = word[REG_MSB:REG_LSB];
  assign imm    = word[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/asic_fetch_decode.sv
// Instruction fetch/decode stage: walks the ROM from a program counter, decodes each word
// and hands it to execute over valid/ready, stopping when a HALT opcode is read.
module asic_fetch_decode
  import asic_isa_pkg::*;
#(
  parameter int D_WIDTH    = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic               clka,
  input  logic               rsta_n,
  asic_fetch_decode_if.master bus
);

  // Last valid ROM address; the PC wraps here even when DEPTH is not a power of two
  localparam logic [ADDR_WIDTH-1:0] PC_LAST = ADDR_WIDTH'(DEPTH - 1);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] ins_pc_q;
  logic [3:0]            op_q;
  logic [3:0]            reg_q;
  logic [7:0]            imm_q;
  logic [3:0]            dec_op;
  logic [3:0]            dec_reg;
  logic [7:0]            dec_imm;

  asic_ins_decode #(
    .D_WIDTH(D_WIDTH)
  ) u_decode (
    .word   (bus.rom_data),
    .op     (dec_op),
    .rfield (dec_reg),
    .imm    (dec_imm)
  );

  assign pc_inc = (pc == PC_LAST) ? '0 : pc + ADDR_WIDTH'(1);

  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.rom_ena   = 1'b0;
    bus.ins_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.halted    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        bus.rom_ena = 1'b1;
        bus.busy    = 1'b1;
        state_nxt   = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        bus.busy  = 1'b1;
        state_nxt = is_halt(dec_op) ? ST_HALT : ST_ISSUE;
      end
      ST_ISSUE: begin
        bus.ins_valid = 1'b1;
        bus.busy      = 1'b1;
        if (bus.ins_ready) state_nxt = ST_FETCH;
      end
      ST_HALT: begin
        bus.halted = 1'b1;
        if (bus.start) state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Fields only load in CAPTURE, so they stay frozen through any ISSUE stall
  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      pc       <= '0;
      ins_pc_q <= '0;
      op_q     <= '0;
      reg_q    <= '0;
      imm_q    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (bus.start) pc <= bus.start_addr;
        end
        ST_CAPTURE: begin
          if (!is_halt(dec_op)) begin
            op_q     <= dec_op;
            reg_q    <= dec_reg;
            imm_q    <= dec_imm;
            ins_pc_q <= pc;
            pc       <= pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rom_addr = pc;
  assign bus.ins_op   = op_q;
  assign bus.ins_reg  = reg_q;
  assign bus.ins_imm  = imm_q;
  assign bus.ins_pc   = ins_pc_q;

endmodule

// File: tb/tb_asic_fetch_decode.sv
// Self-checking bench for asic_fetch_decode: a 256-deep instance running a 16-word program
// from a behavioural ROM, plus a DEPTH=16 instance exercising PC wrap-around.
module tb_asic_fetch_decode;

  typedef struct {
    logic [7:0] pc;
    logic [3:0] op;
    logic [3:0] rg;
    logic [7:0] imm;
  } issue_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [15:0] prog_rom [0:15];
  logic [15:0] wrap_rom [0:15];
  issue_t      exp_main [0:14];
  issue_t      exp_restart [0:1];
  issue_t      exp_wrap [0:3];

  asic_fetch_decode_if #(.ADDR_WIDTH(8), .D_WIDTH(16)) fd_if ();
  asic_fetch_decode_if #(.ADDR_WIDTH(8), .D_WIDTH(16)) wr_if ();

  asic_fetch_decode #(.D_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(256)) dut (
    .clka   (clk),
    .rsta_n (rst_n),
    .bus    (fd_if.master)
  );

  asic_fetch_decode #(.D_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(16)) dut_wrap (
    .clka   (clk),
    .rsta_n (rst_n),
    .bus    (wr_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read ROM models: data appears the cycle after ena
  always @(posedge clk) begin
    if (fd_if.rom_ena) fd_if.rom_data <= prog_rom[fd_if.rom_addr[3:0]];
    if (wr_if.rom_ena) wr_if.rom_data <= wrap_rom[wr_if.rom_addr[3:0]];
  end

  task automatic apply_stimulus(input logic st, input logic [7:0] addr, input logic rdy);
    fd_if.start      = st;
    fd_if.start_addr = addr;
    fd_if.ins_ready  = rdy;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  function automatic logic [23:0] pack_issue(input issue_t e);
    return {e.pc, e.op, e.rg, e.imm};
  endfunction

  initial begin
    int k;
    int cycles;

    checks = 0;
    errors = 0;

    prog_rom = '{16'h5000, 16'h310F, 16'h321A, 16'h4355, 16'h7480, 16'h2501, 16'h1677, 16'h8702,
                 16'h93FF, 16'hA910, 16'hBA44, 16'hCB21, 16'hDC0E, 16'h6100, 16'h6200, 16'hF000};
    for (int i = 0; i < 16; i++) wrap_rom[i] = {4'h2, 4'(i), 8'hC0 + 8'(i)};

    exp_main = '{
      '{8'd0,  4'h5, 4'h0, 8'h00}, '{8'd1,  4'h3, 4'h1, 8'h0F}, '{8'd2,  4'h3, 4'h2, 8'h1A},
      '{8'd3,  4'h4, 4'h3, 8'h55}, '{8'd4,  4'h7, 4'h4, 8'h80}, '{8'd5,  4'h2, 4'h5, 8'h01},
      '{8'd6,  4'h1, 4'h6, 8'h77}, '{8'd7,  4'h8, 4'h7, 8'h02}, '{8'd8,  4'h9, 4'h3, 8'hFF},
      '{8'd9,  4'hA, 4'h9, 8'h10}, '{8'd10, 4'hB, 4'hA, 8'h44}, '{8'd11, 4'hC, 4'hB, 8'h21},
      '{8'd12, 4'hD, 4'hC, 8'h0E}, '{8'd13, 4'h6, 4'h1, 8'h00}, '{8'd14, 4'h6, 4'h2, 8'h00}
    };
    exp_restart = '{'{8'd13, 4'h6, 4'h1, 8'h00}, '{8'd14, 4'h6, 4'h2, 8'h00}};
    exp_wrap    = '{'{8'd14, 4'h2, 4'hE, 8'hCE}, '{8'd15, 4'h2, 4'hF, 8'hCF},
                    '{8'd0,  4'h2, 4'h0, 8'hC0}, '{8'd1,  4'h2, 4'h1, 8'hC1}};

    // Reset held two cycles
    rst_n = 1'b0;
    apply_stimulus(1'b0, 8'd0, 1'b0);
    wr_if.start      = 1'b0;
    wr_if.start_addr = 8'd0;
    wr_if.ins_ready  = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 8'd0, 1'b1);
    @(negedge clk);
    check_output("rst_rom_ena",   32'(fd_if.rom_ena),   0);
    check_output("rst_rom_addr",  32'(fd_if.rom_addr),  0);
    check_output("rst_ins_valid", 32'(fd_if.ins_valid), 0);
    check_output("rst_fields",    32'({fd_if.ins_pc, fd_if.ins_op, fd_if.ins_reg, fd_if.ins_imm}), 0);
    check_output("rst_busy",      32'(fd_if.busy),      0);
    check_output("rst_halted",    32'(fd_if.halted),    0);

    // Run from address 0 with ready high; stall on word 2, stray start on word 4
    apply_stimulus(1'b1, 8'd0, 1'b1);
    @(negedge clk);
    apply_stimulus(1'b0, 8'd0, 1'b1);
    check_output("fetch_rom_ena",  32'(fd_if.rom_ena),  1);
    check_output("fetch_rom_addr", 32'(fd_if.rom_addr), 0);
    check_output("fetch_busy",     32'(fd_if.busy),     1);
    @(negedge clk);
    check_output("capture_valid",  32'(fd_if.ins_valid), 0);
    check_output("capture_rom_ena", 32'(fd_if.rom_ena), 0);
    @(negedge clk);
    check_output("latency_valid",  32'(fd_if.ins_valid), 1);

    k = 0;
    cycles = 0;
    while (!fd_if.halted && cycles < 400) begin
      if (fd_if.ins_valid) begin
        if (k < 15) begin
          check_output($sformatf("main_issue%0d", k),
                       32'({fd_if.ins_pc, fd_if.ins_op, fd_if.ins_reg, fd_if.ins_imm}),
                       32'(pack_issue(exp_main[k])));
        end else begin
          check_output("main_extra_issue", 32'(k), 14);
        end
        if (k == 2) begin
          apply_stimulus(1'b0, 8'd0, 1'b0);
          for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            cycles++;
            check_output($sformatf("stall%0d_valid", s), 32'(fd_if.ins_valid), 1);
            check_output($sformatf("stall%0d_fields", s),
                         32'({fd_if.ins_pc, fd_if.ins_op, fd_if.ins_reg, fd_if.ins_imm}),
                         32'(pack_issue(exp_main[2])));
            check_output($sformatf("stall%0d_rom_ena", s), 32'(fd_if.rom_ena), 0);
          end
          apply_stimulus(1'b0, 8'd0, 1'b1);
          @(negedge clk);
          cycles++;
          check_output("post_stall_valid",    32'(fd_if.ins_valid), 0);
          check_output("post_stall_rom_ena",  32'(fd_if.rom_ena),   1);
          check_output("post_stall_rom_addr", 32'(fd_if.rom_addr),  3);
        end else if (k == 4) begin
          apply_stimulus(1'b1, 8'd9, 1'b1);
          @(negedge clk);
          cycles++;
          apply_stimulus(1'b0, 8'd0, 1'b1);
          check_output("busy_start_rom_ena",  32'(fd_if.rom_ena),  1);
          check_output("busy_start_rom_addr", 32'(fd_if.rom_addr), 5);
        end
        k++;
      end
      if (fd_if.halted) break;
      @(negedge clk);
      cycles++;
    end
    check_output("main_halted",      32'(fd_if.halted), 1);
    check_output("main_issue_count", 32'(k), 15);
    for (int h = 0; h < 3; h++) begin
      check_output($sformatf("halt%0d_rom_ena", h), 32'(fd_if.rom_ena), 0);
      check_output($sformatf("halt%0d_state", h), 32'({fd_if.halted, fd_if.busy, fd_if.ins_valid}), 32'h4);
      @(negedge clk);
    end

    // Restart from HALT at address 13
    apply_stimulus(1'b1, 8'd13, 1'b1);
    @(negedge clk);
    apply_stimulus(1'b0, 8'd0, 1'b1);
    check_output("restart_rom_addr", 32'(fd_if.rom_addr), 13);
    k = 0;
    cycles = 0;
    while (!fd_if.halted && cycles < 40) begin
      if (fd_if.ins_valid) begin
        if (k < 2) begin
          check_output($sformatf("restart_issue%0d", k),
                       32'({fd_if.ins_pc, fd_if.ins_op, fd_if.ins_reg, fd_if.ins_imm}),
                       32'(pack_issue(exp_restart[k])));
        end
        k++;
      end
      @(negedge clk);
      cycles++;
    end
    check_output("restart_halted",      32'(fd_if.halted), 1);
    check_output("restart_issue_count", 32'(k), 2);

    // Reset while an instruction sits unaccepted in ISSUE
    apply_stimulus(1'b1, 8'd0, 1'b0);
    @(negedge clk);
    apply_stimulus(1'b0, 8'd0, 1'b0);
    cycles = 0;
    while (!fd_if.ins_valid && cycles < 10) begin
      @(negedge clk);
      cycles++;
    end
    check_output("midrst_pre_valid", 32'(fd_if.ins_valid), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("midrst_valid",    32'(fd_if.ins_valid), 0);
    check_output("midrst_busy",     32'(fd_if.busy),      0);
    check_output("midrst_halted",   32'(fd_if.halted),    0);
    check_output("midrst_pc",       32'(fd_if.rom_addr),  0);
    check_output("midrst_fields",   32'({fd_if.ins_pc, fd_if.ins_op, fd_if.ins_reg, fd_if.ins_imm}), 0);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 8'd0, 1'b1);
    @(negedge clk);
    check_output("midrst_idle_rom_ena", 32'(fd_if.rom_ena), 0);

    // PC wrap on the DEPTH=16 instance
    wr_if.start      = 1'b1;
    wr_if.start_addr = 8'd14;
    @(negedge clk);
    wr_if.start = 1'b0;
    k = 0;
    cycles = 0;
    while (k < 4 && cycles < 40) begin
      if (wr_if.ins_valid) begin
        check_output($sformatf("wrap_issue%0d", k),
                     32'({wr_if.ins_pc, wr_if.ins_op, wr_if.ins_reg, wr_if.ins_imm}),
                     32'(pack_issue(exp_wrap[k])));
        k++;
      end
      @(negedge clk);
      cycles++;
    end
    check_output("wrap_issue_count", 32'(k), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
